// File: rtl/bicubic_nx_simd_unpack.sv
// Nx SIMD INT9xUINT8 multiplier back end: lane split with borrow fix, rounding, UINT8 clamp.
// Optional saturation counter enabled by defining BICUBIC_UNPACK_SAT_CNT_EN.
module bicubic_nx_simd_unpack #(
   parameter int PARALLEL_CORE = 8,
   parameter int FRAC_BITS     = 7
) (
   input  logic                       clk,
   input  logic                       aresetn,
   input  logic                       clken,
   input  logic [PARALLEL_CORE*48-1:0] din,
   input  logic                       din_valid,
   output logic                       din_ready,
   output logic [PARALLEL_CORE*8-1:0] dout_l,
   output logic [PARALLEL_CORE*8-1:0] dout_h,
   output logic                       dout_valid,
   input  logic                       dout_ready
`ifdef BICUBIC_UNPACK_SAT_CNT_EN
   ,
   input  logic                       sat_clr,
   output logic [31:0]                sat_count
`endif
);

   localparam logic signed [18:0] RND = 19'sd1 <<< (FRAC_BITS - 1);

   logic              s1_valid;
   logic              s1_adv;
   logic              s2_adv;
   logic signed [18:0] r_l [PARALLEL_CORE];
   logic signed [18:0] r_h [PARALLEL_CORE];

   function automatic logic signed [18:0] round_l(input logic [47:0] w);
      return $signed({w[17], w[17:0]}) + RND;
   endfunction

   // adding w[17] back to the upper field undoes the borrow taken by a negative low lane
   function automatic logic signed [18:0] round_h(input logic [47:0] w);
      logic [17:0] h;
      h = w[35:18] + {17'd0, w[17]};
      return $signed({h[17], h}) + RND;
   endfunction

   function automatic logic [7:0] clamp_u8(input logic signed [18:0] r);
      logic signed [18:0] q;
      q = r >>> FRAC_BITS;
      if (q < 19'sd0)
         return 8'd0;
      else if (q > 19'sd255)
         return 8'd255;
      else
         return q[7:0];
   endfunction

   // handshake: each stage advances when the stage behind it can take its contents
   always_comb begin
      s2_adv    = !dout_valid || dout_ready;
      s1_adv    = !s1_valid || s2_adv;
      din_ready = aresetn && clken && s1_adv;
   end

   // stage 1: lane split plus rounding offset
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         s1_valid <= 1'b0;
         for (int i = 0; i < PARALLEL_CORE; i++) begin
            r_l[i] <= 19'sd0;
            r_h[i] <= 19'sd0;
         end
      end else if (clken && s1_adv) begin
         s1_valid <= din_valid && din_ready;
         if (din_valid) begin
            for (int i = 0; i < PARALLEL_CORE; i++) begin
               r_l[i] <= round_l(din[48*i +: 48]);
               r_h[i] <= round_h(din[48*i +: 48]);
            end
         end
      end
   end

   // stage 2: drop fraction bits and clamp into the output pixel registers
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         dout_valid <= 1'b0;
         dout_l     <= '0;
         dout_h     <= '0;
      end else if (clken && s2_adv) begin
         dout_valid <= s1_valid;
         if (s1_valid) begin
            for (int i = 0; i < PARALLEL_CORE; i++) begin
               dout_l[8*i +: 8] <= clamp_u8(r_l[i]);
               dout_h[8*i +: 8] <= clamp_u8(r_h[i]);
            end
         end
      end
   end

`ifdef BICUBIC_UNPACK_SAT_CNT_EN
   logic [31:0] sat_inc;
   logic [32:0] sat_sum;
   logic        s2_load;

   function automatic logic is_sat(input logic signed [18:0] r);
      logic signed [18:0] q;
      q = r >>> FRAC_BITS;
      return (q < 19'sd0) || (q > 19'sd255);
   endfunction

   // lanes clamped by the beat currently moving into stage 2
   always_comb begin
      s2_load = clken && s2_adv && s1_valid;
      sat_inc = 32'd0;
      if (s2_load) begin
         for (int i = 0; i < PARALLEL_CORE; i++) begin
            sat_inc = sat_inc + {31'd0, is_sat(r_l[i])} + {31'd0, is_sat(r_h[i])};
         end
      end else begin
         sat_inc = 32'd0;
      end
      sat_sum = {1'b0, sat_count} + {1'b0, sat_inc};
   end

   // saturating counter; a clear restarts it from this cycle's increment
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn)
         sat_count <= 32'd0;
      else if (clken) begin
         if (sat_clr)
            sat_count <= sat_inc;
         else if (sat_sum[32])
            sat_count <= 32'hFFFF_FFFF;
         else
            sat_count <= sat_sum[31:0];
      end
   end
`endif

endmodule

// File: tb/tb_bicubic_nx_simd_unpack.sv
// Self-checking bench for bicubic_nx_simd_unpack: directed cases plus a randomized stream
// scored against an integer-arithmetic reference model.
module tb_bicubic_nx_simd_unpack;
   localparam int PC = 8;
   localparam int FB = 7;
   localparam int DV = 1 << FB;

   logic              clk = 1'b0;
   logic              aresetn;
   logic              clken;
   logic [PC*48-1:0]  din;
   logic              din_valid;
   logic              din_ready;
   logic [PC*8-1:0]   dout_l;
   logic [PC*8-1:0]   dout_h;
   logic              dout_valid;
   logic              dout_ready;
`ifdef BICUBIC_UNPACK_SAT_CNT_EN
   logic              sat_clr;
   logic [31:0]       sat_count;
   logic [31:0]       sat_base;
`endif

   int n_chk  = 0;
   int n_pass = 0;
   logic [63:0] exp_l_q[$];
   logic [63:0] exp_h_q[$];

   bicubic_nx_simd_unpack #(.PARALLEL_CORE(PC), .FRAC_BITS(FB)) dut (
      .clk(clk), .aresetn(aresetn), .clken(clken),
      .din(din), .din_valid(din_valid), .din_ready(din_ready),
      .dout_l(dout_l), .dout_h(dout_h), .dout_valid(dout_valid), .dout_ready(dout_ready)
`ifdef BICUBIC_UNPACK_SAT_CNT_EN
      , .sat_clr(sat_clr), .sat_count(sat_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic int s18(input int x);
      return (x >= 131072) ? x - 262144 : x;
   endfunction

   // round half up at the fraction point (floor division), then clamp to 0..255
   function automatic int pix(input int v);
      int t, q;
      t = v + DV / 2;
      q = (t >= 0) ? t / DV : -((-t + DV - 1) / DV);
      if (q < 0) return 0;
      if (q > 255) return 255;
      return q;
   endfunction

   task automatic model(input logic [PC*48-1:0] d, output logic [63:0] ml, output logic [63:0] mh);
      logic [47:0] w;
      int lv, hv;
      ml = 64'd0;
      mh = 64'd0;
      for (int i = 0; i < PC; i++) begin
         w  = d[48*i +: 48];
         lv = s18(int'(w[17:0]));
         hv = s18((int'(w[35:18]) + int'(w[17])) % 262144);
         ml[8*i +: 8] = 8'(pix(lv));
         mh[8*i +: 8] = 8'(pix(hv));
      end
   endtask

   function automatic logic [47:0] rnd_word();
      logic [47:0] w;
      w = {16'($urandom), 32'($urandom)};
      if ($urandom_range(0, 1) == 1) begin
         w[17:0]  = 18'($urandom_range(0, 33800) - 600);
         w[35:18] = 18'($urandom_range(0, 33800) - 600);
      end
      return w;
   endfunction

   task automatic send_one(input logic [47:0] w, input logic [7:0] el, input logic [7:0] eh);
      logic [63:0] ml, mh;
      din = '0;
      din[47:0] = w;
      din_valid = 1'b1;
      dout_ready = 1'b1;
      model(din, ml, mh);
      @(negedge clk);
      check("accept_ready", 64'(din_ready), 64'd1);
      @(posedge clk); #1;
      din_valid = 1'b0;
      @(negedge clk);
      check("lat_1edge", 64'(dout_valid), 64'd0);
      @(posedge clk); #1;
      @(negedge clk);
      check("lat_2edge", 64'(dout_valid), 64'd1);
      check("core0_l", 64'(dout_l[7:0]), 64'(el));
      check("core0_h", 64'(dout_h[7:0]), 64'(eh));
      check("vec_l", dout_l, ml);
      check("vec_h", dout_h, mh);
      @(posedge clk); #1;
   endtask

   task automatic run(input int nbeats, input int st_a, input int st_n, input int off_a,
                      input int off_n, input bit rnd, input bit drain);
      int sent = 0;
      bit hold = 1'b0;
      logic pv;
      logic [63:0] pl, ph, ml, mh;
      for (int cyc = 0; cyc < 600; cyc++) begin
         if (sent == nbeats && (!drain || exp_l_q.size() == 0)) break;
         clken = !(cyc >= off_a && cyc < off_a + off_n);
         dout_ready = (cyc >= st_a && cyc < st_a + st_n) ? 1'b0 :
                      (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
         din_valid = (sent < nbeats) && (!rnd || $urandom_range(0, 3) != 0);
         for (int k = 0; k < PC; k++) din[48*k +: 48] = rnd_word();
         @(negedge clk);
         check("din_ready", 64'(din_ready),
               64'(clken && (exp_l_q.size() < 2 || dout_ready)));
         if (hold) begin
            check("hold_valid", 64'(dout_valid), 64'(pv));
            check("hold_l", dout_l, pl);
            check("hold_h", dout_h, ph);
         end
         hold = !clken || (dout_valid && !dout_ready);
         pv = dout_valid;
         pl = dout_l;
         ph = dout_h;
         if (clken && dout_valid && dout_ready) begin
            if (exp_l_q.size() == 0)
               check("spurious_beat", 64'(dout_valid), 64'd0);
            else begin
               check("data_l", dout_l, exp_l_q.pop_front());
               check("data_h", dout_h, exp_h_q.pop_front());
            end
         end
         if (din_valid && din_ready) begin
            model(din, ml, mh);
            exp_l_q.push_back(ml);
            exp_h_q.push_back(mh);
            sent++;
         end
         @(posedge clk); #1;
      end
      din_valid = 1'b0;
      clken = 1'b1;
      check("beats_sent", 64'(sent), 64'(nbeats));
      if (drain) check("drained", 64'(exp_l_q.size()), 64'd0);
   endtask

   initial begin
      aresetn = 1'b0;
      clken = 1'b1;
      din = '0;
      din_valid = 1'b0;
      dout_ready = 1'b0;
`ifdef BICUBIC_UNPACK_SAT_CNT_EN
      sat_clr = 1'b0;
`endif
      #12;
      check("rst_valid", 64'(dout_valid), 64'd0);
      check("rst_l", dout_l, 64'd0);
      check("rst_h", dout_h, 64'd0);
      check("rst_ready", 64'(din_ready), 64'd0);
`ifdef BICUBIC_UNPACK_SAT_CNT_EN
      check("rst_sat", 64'(sat_count), 64'd0);
`endif
      @(negedge clk) aresetn = 1'b1;
      @(posedge clk); #1;

      send_one(48'd32640, 8'd255, 8'd0);
      send_one((48'd8192 << 18) + 48'hFFFF_FFFF_FFFF, 8'd0, 8'd64);
`ifdef BICUBIC_UNPACK_SAT_CNT_EN
      sat_base = sat_count;
`endif
      send_one(48'(191), 8'd1, 8'd0);
      send_one(48'(192), 8'd2, 8'd0);
      send_one(48'(-300), 8'd0, 8'd0);
      send_one(48'(40000), 8'd255, 8'd0);
`ifdef BICUBIC_UNPACK_SAT_CNT_EN
      check("sat_inc2", 64'(sat_count), 64'(sat_base + 32'd2));
      sat_clr = 1'b1;
      @(posedge clk); #1;
      sat_clr = 1'b0;
      check("sat_clear", 64'(sat_count), 64'd0);
`endif

      run(4, 0, 5, 999, 0, 1'b0, 1'b1);
      run(6, 999, 0, 2, 3, 1'b0, 1'b1);
      run(60, 10, 4, 25, 3, 1'b1, 1'b1);

      run(2, 0, 999, 999, 0, 1'b0, 1'b0);
      #2 aresetn = 1'b0;
      #1;
      check("arst_valid", 64'(dout_valid), 64'd0);
      check("arst_l", dout_l, 64'd0);
      check("arst_h", dout_h, 64'd0);
      check("arst_ready", 64'(din_ready), 64'd0);
      exp_l_q.delete();
      exp_h_q.delete();
      @(posedge clk); #1;
      aresetn = 1'b1;
      dout_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("no_stale", 64'(dout_valid), 64'd0);
         @(posedge clk); #1;
      end
      run(5, 999, 0, 999, 0, 1'b0, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
